// File: rtl/sparse_cnn_pkg.sv
// Shared types and helpers for the sparse-conv partial-sum accumulator:
// output map sizing, control FSM states and the requantiser.
package sparse_cnn_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DRAIN} psum_state_e;

  function automatic int out_dim(input int data_rows, input int ksize);
    return data_rows - ksize + 1;
  endfunction

  // Arithmetic right shift then clamp to a signed out_w-bit range.
  function automatic logic signed [31:0] sat_shift(input logic signed [31:0] v,
                                                   input int shift, input int out_w);
    logic signed [31:0] s, hi, lo;
    s  = v >>> shift;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/psum_lane_serializer.sv
// Holds one PE beat and issues its valid lanes lowest index first, one per
// cycle; iss_fin marks the cycle the beat is finished (also for an empty mask).
module psum_lane_serializer #(
  parameter int LANES  = 4,
  parameter int PROD_W = 16,
  parameter int COL_W  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic [LANES-1:0]               lane_vld,
  input  logic [LANES-1:0][PROD_W-1:0]   data,
  input  logic [LANES-1:0][COL_W-1:0]    rows,
  input  logic [LANES-1:0][COL_W-1:0]    cols,
  output logic                           full,
  output logic                           iss_vld,
  output logic signed [PROD_W-1:0]       iss_data,
  output logic [COL_W-1:0]               iss_row,
  output logic [COL_W-1:0]               iss_col,
  output logic                           iss_fin
);
  localparam int SW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0]             mask, rem;
  logic [LANES-1:0][PROD_W-1:0] d_q;
  logic [LANES-1:0][COL_W-1:0]  r_q, c_q;
  logic [SW-1:0]                sel;
  logic                         hit;

  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        sel = SW'(i);
        hit = 1'b1;
      end
    end
    rem = mask;
    if (hit) rem[sel] = 1'b0;
  end

  assign iss_vld  = full && hit;
  assign iss_fin  = full && (rem == '0);
  assign iss_data = $signed(d_q[sel]);
  assign iss_row  = r_q[sel];
  assign iss_col  = c_q[sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      mask <= '0;
      d_q  <= '0;
      r_q  <= '0;
      c_q  <= '0;
    end else if (load) begin
      full <= 1'b1;
      mask <= lane_vld;
      d_q  <= data;
      r_q  <= rows;
      c_q  <= cols;
    end else if (full) begin
      mask <= rem;
      if (rem == '0) full <= 1'b0;
    end
  end

endmodule

// File: rtl/sparse_psum_accum.sv
// Accumulates coordinate-tagged partial products into a dense partial-sum map
// and streams it out requantised. SPARSE_ACC_RELU_EN clamps negative pixels to 0.
module sparse_psum_accum
  import sparse_cnn_pkg::*;
#(
  parameter int DATA_ROWS = 28,
  parameter int KSIZE     = 5,
  parameter int LANES     = 4,
  parameter int PROD_W    = 16,
  parameter int COL_W     = 8,
  parameter int ACC_W     = 24,
  parameter int OUT_W     = 8,
  parameter int SHIFT     = 4
) (
  input  logic                     clk,
  input  logic                     irst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_lane_vld,
  input  logic [LANES*PROD_W-1:0]  in_data,
  input  logic [LANES*COL_W-1:0]   in_rows,
  input  logic [LANES*COL_W-1:0]   in_cols,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [COL_W-1:0]         out_row,
  output logic [COL_W-1:0]         out_col,
  output logic                     out_last,
  output logic                     busy,
  output logic [15:0]              drop_cnt
);
  localparam int OUT_DIM = out_dim(DATA_ROWS, KSIZE);
  localparam int NPIX    = OUT_DIM * OUT_DIM;
  localparam int AW      = $clog2(NPIX);
  localparam logic [COL_W-1:0] DIM_C  = COL_W'(OUT_DIM);
  localparam logic [COL_W-1:0] LAST_C = COL_W'(OUT_DIM - 1);

  psum_state_e state, state_nxt;

  logic                     ld, last_seen;
  logic                     lat_full, iss_vld, iss_fin;
  logic signed [PROD_W-1:0] iss_data;
  logic [COL_W-1:0]         iss_row, iss_col;

  logic signed [ACC_W-1:0]  map [NPIX];
  logic                     in_rng, a_vld;
  logic [AW-1:0]            iss_addr;
  logic                     s1_vld;
  logic [AW-1:0]            s1_addr;
  logic signed [ACC_W-1:0]  s1_rd, s1_prod, sum_b;

  logic [COL_W-1:0]         rd_row, rd_col;
  logic [AW-1:0]            drain_addr;
  logic signed [31:0]       pix32;
  logic [OUT_W-1:0]         q;

  assign busy     = (state != IDLE);
  assign in_ready = (state == ACCUM) && !last_seen && (!lat_full || iss_fin);
  assign ld       = in_valid && in_ready;

  psum_lane_serializer #(.LANES(LANES), .PROD_W(PROD_W), .COL_W(COL_W)) u_ser (
    .clk      (clk),
    .rst_n    (irst_n),
    .load     (ld),
    .lane_vld (in_lane_vld),
    .data     (in_data),
    .rows     (in_rows),
    .cols     (in_cols),
    .full     (lat_full),
    .iss_vld  (iss_vld),
    .iss_data (iss_data),
    .iss_row  (iss_row),
    .iss_col  (iss_col),
    .iss_fin  (iss_fin)
  );

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = CLEAR;
      CLEAR: state_nxt = ACCUM;
      ACCUM: if (last_seen && !lat_full && !s1_vld) state_nxt = DRAIN;
      DRAIN: if (out_valid && out_ready && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n)                         last_seen <= 1'b0;
    else if (state == CLEAR)             last_seen <= 1'b0;
    else if (ld && in_last)              last_seen <= 1'b1;
  end

  // Stage 1 reads the map; a hit on the entry stage 2 is writing takes its sum.
  assign in_rng   = (iss_row < DIM_C) && (iss_col < DIM_C);
  assign a_vld    = iss_vld && in_rng && (state == ACCUM);
  assign iss_addr = in_rng ? AW'(iss_row * OUT_DIM + iss_col) : '0;
  assign sum_b    = s1_rd + s1_prod;

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      s1_vld  <= 1'b0;
      s1_addr <= '0;
      s1_rd   <= '0;
      s1_prod <= '0;
    end else begin
      s1_vld  <= a_vld;
      s1_addr <= iss_addr;
      s1_prod <= ACC_W'(iss_data);
      s1_rd   <= (s1_vld && s1_addr == iss_addr) ? sum_b : map[iss_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      for (int i = 0; i < NPIX; i++) map[i] <= '0;
    end else if (s1_vld) begin
      map[s1_addr] <= sum_b;
    end
  end

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n)                                  drop_cnt <= '0;
    else if (state == CLEAR)                      drop_cnt <= '0;
    else if (state == ACCUM && iss_vld && !in_rng && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end

  assign drain_addr = AW'(rd_row * OUT_DIM + rd_col);
  assign pix32      = 32'(map[drain_addr]);
`ifdef SPARSE_ACC_RELU_EN
  assign q = (sat_shift(pix32, SHIFT, OUT_W) < 0) ? '0 : OUT_W'(sat_shift(pix32, SHIFT, OUT_W));
`else
  assign q = OUT_W'(sat_shift(pix32, SHIFT, OUT_W));
`endif

  // Output register refills whenever empty or consumed; holds while stalled.
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
    end else if (state == CLEAR) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      rd_row    <= '0;
      rd_col    <= '0;
    end else if (state == DRAIN) begin
      if (out_valid && out_ready && out_last) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_data  <= q;
        out_row   <= rd_row;
        out_col   <= rd_col;
        out_last  <= (rd_row == LAST_C) && (rd_col == LAST_C);
        if (rd_col == LAST_C) begin
          rd_col <= '0;
          rd_row <= rd_row + 1'b1;
        end else begin
          rd_col <= rd_col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sparse_psum_accum.sv
// Directed bench for sparse_psum_accum: table of single-frame vectors plus
// hand-written stall and mid-frame reset sequences.
module tb_sparse_psum_accum;
  localparam int NPIX = 576;

  logic        clk = 1'b0;
  logic        irst_n;
  logic        start, in_valid, in_ready, in_last;
  logic [3:0]  in_lane_vld;
  logic [63:0] in_data;
  logic [31:0] in_rows, in_cols;
  logic        out_valid, out_ready, out_last, busy;
  logic [7:0]  out_data, out_row, out_col;
  logic [15:0] drop_cnt;

  sparse_psum_accum dut (
    .clk(clk), .irst_n(irst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_vld(in_lane_vld), .in_data(in_data), .in_rows(in_rows), .in_cols(in_cols),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  vld;
    logic [63:0] d;
    logic [31:0] r, c;
    int          reps, idx, exp, drop;
  } vec_t;

  vec_t tv[9];
  int   n_vec = 0, n_err = 0;
  int   pix[NPIX];
  int   got, order_err, stall_err, last_err;

  function automatic int rq(input int v);
`ifdef SPARSE_ACC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_beat(input logic [3:0] v, input logic [63:0] d,
                           input logic [31:0] r, input logic [31:0] c, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_lane_vld = v; in_data = d; in_rows = r; in_cols = c; in_last = l;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1 repeating
  task automatic drain(input int mode);
    logic       done, was_stall;
    logic [7:0] hd, hr, hc;
    got = 0; order_err = 0; stall_err = 0; last_err = 0;
    done = 1'b0; was_stall = 1'b0; hd = '0; hr = '0; hc = '0;
    for (int k = 0; k < 4000 && !done; k++) begin
      @(negedge clk);
      out_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      #1;
      if (was_stall && (!out_valid || out_data !== hd || out_row !== hr || out_col !== hc))
        stall_err++;
      was_stall = out_valid && !out_ready;
      hd = out_data; hr = out_row; hc = out_col;
      if (out_valid && out_ready) begin
        if (got < NPIX) pix[got] = int'($signed(out_data));
        if (int'(out_row) != got / 24 || int'(out_col) != got % 24) order_err++;
        if (out_last !== (got == NPIX - 1)) last_err++;
        got++;
        if (out_last) done = 1'b1;
      end
    end
    if (!done) chk("drain_timeout", 0, 1);
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk("busy_after_drain", busy, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int nz = 0;
    do_start();
    for (int b = 0; b < v.reps; b++) send_beat(v.vld, v.d, v.r, v.c, b == v.reps - 1);
    drain(0);
    for (int k = 0; k < NPIX; k++) if (k != v.idx && pix[k] != 0) nz++;
    chk({v.name, "_pixel"}, pix[v.idx], v.exp);
    chk({v.name, "_others_nonzero"}, nz, 0);
    chk({v.name, "_drop_cnt"}, drop_cnt, v.drop);
    chk({v.name, "_stream_errs"}, order_err + last_err + ((got != NPIX) ? 1 : 0), 0);
  endtask

  initial begin
    tv[0] = '{"one_lane",  4'b0001, {48'd0, 16'd100}, 32'h0, 32'h0, 1, 0, 6, 0};
    tv[1] = '{"rmw_fwd",   4'b1111, {16'd40, 16'd30, 16'd20, 16'd10}, {4{8'd3}}, {4{8'd5}}, 1, 77, 6, 0};
    tv[2] = '{"drop_row",  4'b0011, {32'd0, 16'd32, 16'd7}, {16'd0, 8'd1, 8'd24}, {16'd0, 8'd1, 8'd0}, 1, 25, 2, 1};
    tv[3] = '{"neg_sat",   4'b0001, {48'd0, 16'hFE70}, 32'h0, 32'h0, 20, 0, rq(-128), 0};
    tv[4] = '{"corner",    4'b1010, {16'hFFEC, 16'd0, 16'd300, 16'd0}, {8'd23, 8'd0, 8'd23, 8'd0}, {8'd23, 8'd0, 8'd23, 8'd0}, 1, 575, 17, 0};
    tv[5] = '{"empty",     4'b0000, {4{16'd500}}, 32'h0, 32'h0, 1, 0, 0, 0};
    tv[6] = '{"pos_sat",   4'b0001, {48'd0, 16'd3000}, {24'd0, 8'd10}, {24'd0, 8'd10}, 1, 250, 127, 0};
    tv[7] = '{"neg_small", 4'b0001, {48'd0, 16'hFFFF}, 32'h0, {24'd0, 8'd1}, 1, 1, rq(-1), 0};
    tv[8] = '{"drop_col",  4'b1000, {16'd50, 48'hFFFF_1234_4321}, {8'd5, 24'd0}, {8'd30, 24'd0}, 1, 0, 0, 1};

    irst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_lane_vld = '0; in_data = '0; in_rows = '0; in_cols = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outs", {in_ready, out_valid, out_last, busy}, 0);
    chk("rst_data", {out_data, out_row, out_col, drop_cnt}, 0);
    irst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(tv[i]);

    // stall pattern on the output side
    do_start();
    send_beat(4'b0111, {16'd0, 16'd48, 16'd32, 16'd100}, 32'h0, {8'd0, 8'd2, 8'd1, 8'd0}, 1'b1);
    drain(1);
    chk("stall_pix0", pix[0], 6);
    chk("stall_pix1", pix[1], 2);
    chk("stall_pix2", pix[2], 3);
    chk("stall_count", got, NPIX);
    chk("stall_order", order_err + last_err, 0);
    chk("stall_hold", stall_err, 0);

    // reset in the middle of accumulation
    do_start();
    send_beat(4'b0011, {32'd0, 16'd1, 16'd500}, {16'd0, 8'd30, 8'd2}, {16'd0, 8'd0, 8'd2}, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_drop_before_rst", drop_cnt, 1);
    chk("mid_busy_before_rst", busy, 1);
    irst_n = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_outs", {in_ready, out_valid, out_last, busy}, 0);
    chk("mid_rst_data", {out_data, out_row, out_col, drop_cnt}, 0);
    irst_n = 1'b1;
    do_start();
    send_beat(4'b0001, {48'd0, 16'd16}, 32'h0, {24'd0, 8'd1}, 1'b1);
    drain(0);
    chk("post_rst_cleared", pix[50], 0);
    chk("post_rst_pix1", pix[1], 1);
    chk("post_rst_count", got, NPIX);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
